// File: rtl/roce_mem_pkg.sv
// Shared types for the RoCE memory responder: command layout, engine states
// and the burst arithmetic used by both engines.
package roce_mem_pkg;
  localparam int CMD_WIDTH = 96;

  typedef struct packed {
    logic [31:0] length;
    logic [63:0] address;
  } mem_cmd_t;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_DATA  = 2'd1,
    WR_DRAIN = 2'd2
  } wr_state_e;

  // Number of 64-bit beats covering a byte length (ceil(length/8)).
  function automatic logic [31:0] beat_count(input logic [31:0] length);
    return {3'b000, length[31:3]} + {31'd0, |length[2:0]};
  endfunction

  // Byte-valid mask of the final beat given length[2:0].
  function automatic logic [7:0] tail_keep(input logic [2:0] rem);
    logic [7:0] keep;
    keep = (8'd1 << rem) - 8'd1;
    return (rem == 3'd0) ? 8'hFF : keep;
  endfunction
endpackage

// File: rtl/mem_resp_skid.sv
// Two-entry AXI-Stream skid buffer for read beats. The producer tracks credit
// through 'count' and never pushes while both entries are occupied.
module mem_resp_skid #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [WIDTH/8-1:0] in_keep,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [WIDTH/8-1:0] out_keep,
  output logic               out_last,
  output logic [1:0]         count
);
  localparam int EW = WIDTH + WIDTH / 8 + 1;

  logic [EW-1:0] head_q, head_d, tail_q, tail_d, in_ent;
  logic [1:0]    count_q, count_d;
  logic          pop;

  assign in_ent = {in_last, in_keep, in_data};
  assign pop    = out_valid & out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({in_valid, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = in_ent;
        else                 tail_d = in_ent;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy is unchanged; the new beat lands behind whatever remains.
        if (count_q == 2'd2) begin
          head_d = tail_q;
          tail_d = in_ent;
        end else begin
          head_d = in_ent;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign out_valid                      = (count_q != 2'd0);
  assign {out_last, out_keep, out_data} = head_q;
  assign count                          = count_q;
endmodule

// File: rtl/roce_mem_responder.sv
// RoCE memory responder: byte-addressed read/write bursts against a local
// dual-port word memory, write engine on port A, read engine on port B.
module roce_mem_responder
  import roce_mem_pkg::*;
#(
  parameter int WIDTH         = 64,
  parameter int MEM_ADDR_BITS = 12
) (
  input  logic                 net_clk,
  input  logic                 net_areset,
  input  logic                 s_axis_mem_read_cmd_valid,
  output logic                 s_axis_mem_read_cmd_ready,
  input  logic [CMD_WIDTH-1:0] s_axis_mem_read_cmd_data,
  input  logic                 s_axis_mem_write_cmd_valid,
  output logic                 s_axis_mem_write_cmd_ready,
  input  logic [CMD_WIDTH-1:0] s_axis_mem_write_cmd_data,
  input  logic                 s_axis_mem_write_data_valid,
  output logic                 s_axis_mem_write_data_ready,
  input  logic                 s_axis_mem_write_data_last,
  input  logic [WIDTH-1:0]     s_axis_mem_write_data_data,
  input  logic [WIDTH/8-1:0]   s_axis_mem_write_data_keep,
  output logic                 m_axis_mem_read_data_valid,
  input  logic                 m_axis_mem_read_data_ready,
  output logic                 m_axis_mem_read_data_last,
  output logic [WIDTH-1:0]     m_axis_mem_read_data_data,
  output logic [WIDTH/8-1:0]   m_axis_mem_read_data_keep,
  output logic [31:0]          wr_len_err_count,
  output logic                 rd_busy,
  output logic                 wr_busy,
  output rd_state_e            rd_state_dbg,
  output wr_state_e            wr_state_dbg
);
  localparam int DEPTH = 1 << MEM_ADDR_BITS;
  localparam int KW    = WIDTH / 8;

  // All streams are AXI-Stream style: a transfer occurs on a rising edge where
  // valid and ready are both 1; valid holds with stable payload until then.
  mem_cmd_t rd_cmd, wr_cmd;
  assign rd_cmd = s_axis_mem_read_cmd_data;
  assign wr_cmd = s_axis_mem_write_cmd_data;

  logic run_q, run_d;
  rd_state_e rd_state_q, rd_state_d;
  logic [MEM_ADDR_BITS-1:0] rd_idx_q, rd_idx_d;
  logic [31:0]   rd_left_q, rd_left_d;
  logic [KW-1:0] rd_tail_keep_q, rd_tail_keep_d;
  logic          rd_pend_q, rd_pend_d, rd_pend_last_q, rd_pend_last_d;
  logic [KW-1:0] rd_pend_keep_q, rd_pend_keep_d;
  logic [WIDTH-1:0] rd_word_q;
  logic [1:0]    skid_count;
  logic          rd_cmd_hs, rd_pop, rd_issue;

  wr_state_e wr_state_q, wr_state_d;
  logic [MEM_ADDR_BITS-1:0] wr_idx_q, wr_idx_d;
  logic [31:0] wr_left_q, wr_left_d, err_q, err_d;
  logic        wr_cmd_hs, wr_dat_hs, wr_we, err_inc;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_cmd.address[63:MEM_ADDR_BITS+3], rd_cmd.address[2:0],
                              wr_cmd.address[63:MEM_ADDR_BITS+3], wr_cmd.address[2:0]};

  assign run_d = 1'b1;
  assign s_axis_mem_read_cmd_ready   = run_q & (rd_state_q == RD_IDLE);
  assign s_axis_mem_write_cmd_ready  = run_q & (wr_state_q == WR_IDLE);
  assign s_axis_mem_write_data_ready = (wr_state_q != WR_IDLE);
  assign rd_cmd_hs = s_axis_mem_read_cmd_valid & s_axis_mem_read_cmd_ready;
  assign wr_cmd_hs = s_axis_mem_write_cmd_valid & s_axis_mem_write_cmd_ready;
  assign wr_dat_hs = s_axis_mem_write_data_valid & s_axis_mem_write_data_ready;
  assign rd_pop    = m_axis_mem_read_data_valid & m_axis_mem_read_data_ready;

  // Credit: buffered beats plus the read in flight, less the beat leaving now.
  assign rd_issue = (rd_state_q == RD_STREAM) &&
                    (({1'b0, skid_count} + {2'b00, rd_pend_q}) < (3'd2 + {2'b00, rd_pop}));

  always_comb begin
    rd_state_d     = rd_state_q;
    rd_idx_d       = rd_idx_q;
    rd_left_d      = rd_left_q;
    rd_tail_keep_d = rd_tail_keep_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (rd_cmd_hs && rd_cmd.length != 32'd0) begin
          rd_state_d     = RD_STREAM;
          rd_idx_d       = rd_cmd.address[MEM_ADDR_BITS+2:3];
          rd_left_d      = beat_count(rd_cmd.length);
          rd_tail_keep_d = tail_keep(rd_cmd.length[2:0]);
        end
      end
      RD_STREAM: begin
        if (rd_issue) begin
          rd_idx_d  = rd_idx_q + 1'b1;
          rd_left_d = rd_left_q - 32'd1;
          if (rd_left_q == 32'd1) rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    rd_pend_d      = rd_issue;
    rd_pend_last_d = rd_issue && (rd_left_q == 32'd1);
    rd_pend_keep_d = (rd_left_q == 32'd1) ? rd_tail_keep_q : '1;
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_idx_d   = wr_idx_q;
    wr_left_d  = wr_left_q;
    wr_we      = 1'b0;
    err_inc    = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (wr_cmd_hs && wr_cmd.length != 32'd0) begin
          wr_state_d = WR_DATA;
          wr_idx_d   = wr_cmd.address[MEM_ADDR_BITS+2:3];
          wr_left_d  = beat_count(wr_cmd.length);
        end
      end
      WR_DATA: begin
        if (wr_dat_hs) begin
          wr_we     = 1'b1;
          wr_idx_d  = wr_idx_q + 1'b1;
          wr_left_d = wr_left_q - 32'd1;
          if (s_axis_mem_write_data_last) begin
            wr_state_d = WR_IDLE;
            err_inc    = (wr_left_q != 32'd1);
          end else if (wr_left_q == 32'd1) begin
            wr_state_d = WR_DRAIN;
            err_inc    = 1'b1;
          end
        end
      end
      WR_DRAIN: begin
        if (wr_dat_hs && s_axis_mem_write_data_last) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
    err_d = (err_inc && err_q != 32'hFFFF_FFFF) ? err_q + 32'd1 : err_q;
  end

  always_ff @(posedge net_clk or posedge net_areset) begin
    if (net_areset) begin
      run_q          <= 1'b0;
      rd_state_q     <= RD_IDLE;
      rd_idx_q       <= '0;
      rd_left_q      <= '0;
      rd_tail_keep_q <= '0;
      rd_pend_q      <= 1'b0;
      rd_pend_last_q <= 1'b0;
      rd_pend_keep_q <= '0;
      wr_state_q     <= WR_IDLE;
      wr_idx_q       <= '0;
      wr_left_q      <= '0;
      err_q          <= '0;
    end else begin
      run_q          <= run_d;
      rd_state_q     <= rd_state_d;
      rd_idx_q       <= rd_idx_d;
      rd_left_q      <= rd_left_d;
      rd_tail_keep_q <= rd_tail_keep_d;
      rd_pend_q      <= rd_pend_d;
      rd_pend_last_q <= rd_pend_last_d;
      rd_pend_keep_q <= rd_pend_keep_d;
      wr_state_q     <= wr_state_d;
      wr_idx_q       <= wr_idx_d;
      wr_left_q      <= wr_left_d;
      err_q          <= err_d;
    end
  end

  // Memory is never reset; port B samples before port A's write lands (read-first).
  always_ff @(posedge net_clk) begin
    if (wr_we) begin
      for (int b = 0; b < KW; b++) begin
        if (s_axis_mem_write_data_keep[b]) mem_q[wr_idx_q][b*8 +: 8] <= s_axis_mem_write_data_data[b*8 +: 8];
      end
    end
    if (rd_issue) rd_word_q <= mem_q[rd_idx_q];
  end

  mem_resp_skid #(.WIDTH(WIDTH)) u_skid (
    .clk       (net_clk),
    .rst       (net_areset),
    .in_valid  (rd_pend_q),
    .in_data   (rd_word_q),
    .in_keep   (rd_pend_keep_q),
    .in_last   (rd_pend_last_q),
    .out_valid (m_axis_mem_read_data_valid),
    .out_ready (m_axis_mem_read_data_ready),
    .out_data  (m_axis_mem_read_data_data),
    .out_keep  (m_axis_mem_read_data_keep),
    .out_last  (m_axis_mem_read_data_last),
    .count     (skid_count)
  );

  assign wr_len_err_count = err_q;
  assign rd_busy          = (rd_state_q != RD_IDLE);
  assign wr_busy          = (wr_state_q != WR_IDLE);
  assign rd_state_dbg     = rd_state_q;
  assign wr_state_dbg     = wr_state_q;
endmodule

// File: tb/tb_roce_mem_responder.sv
// Bench for roce_mem_responder: directed steps plus randomized bursts checked
// against a word-array memory model and an expected-beat queue.
module tb_roce_mem_responder;
  import roce_mem_pkg::*;

  localparam int DEPTH = 4096;
  localparam int EW    = 73;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic          rc_valid = 1'b0, rc_ready;
  logic [95:0]   rc_data  = '0;
  logic          wc_valid = 1'b0, wc_ready;
  logic [95:0]   wc_data  = '0;
  logic          wd_valid = 1'b0, wd_ready, wd_last = 1'b0;
  logic [63:0]   wd_data  = '0;
  logic [7:0]    wd_keep  = '0;
  logic          m_valid, m_ready = 1'b0, m_last;
  logic [63:0]   m_data;
  logic [7:0]    m_keep;
  logic [31:0]   err_cnt;
  logic          rd_busy, wr_busy;
  rd_state_e     rd_state_dbg;
  wr_state_e     wr_state_dbg;

  int tests = 0;
  int fails = 0;
  int exp_err = 0;
  logic [63:0]   mdl [DEPTH];
  logic [EW-1:0] exp_q[$];

  roce_mem_responder dut (
    .net_clk                     (clk),
    .net_areset                  (rst),
    .s_axis_mem_read_cmd_valid   (rc_valid),
    .s_axis_mem_read_cmd_ready   (rc_ready),
    .s_axis_mem_read_cmd_data    (rc_data),
    .s_axis_mem_write_cmd_valid  (wc_valid),
    .s_axis_mem_write_cmd_ready  (wc_ready),
    .s_axis_mem_write_cmd_data   (wc_data),
    .s_axis_mem_write_data_valid (wd_valid),
    .s_axis_mem_write_data_ready (wd_ready),
    .s_axis_mem_write_data_last  (wd_last),
    .s_axis_mem_write_data_data  (wd_data),
    .s_axis_mem_write_data_keep  (wd_keep),
    .m_axis_mem_read_data_valid  (m_valid),
    .m_axis_mem_read_data_ready  (m_ready),
    .m_axis_mem_read_data_last   (m_last),
    .m_axis_mem_read_data_data   (m_data),
    .m_axis_mem_read_data_keep   (m_keep),
    .wr_len_err_count            (err_cnt),
    .rd_busy                     (rd_busy),
    .wr_busy                     (wr_busy),
    .rd_state_dbg                (rd_state_dbg),
    .wr_state_dbg                (wr_state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int beats_of(input logic [31:0] len);
    return int'((longint'(len) + 7) / 8);
  endfunction

  function automatic logic [7:0] keep_for(input logic [31:0] len);
    int rem;
    logic [7:0] k;
    rem = int'(len % 8);
    k = 8'h00;
    if (rem == 0) return 8'hFF;
    for (int b = 0; b < rem; b++) k[b] = 1'b1;
    return k;
  endfunction

  function automatic int idx_of(input logic [63:0] addr);
    return int'(addr[14:3]);
  endfunction

  // Driver tasks
  task automatic send_rd_cmd(input logic [63:0] addr, input logic [31:0] len);
    int n;
    n = 0;
    @(negedge clk);
    rc_valid = 1'b1;
    rc_data  = {len, addr};
    while (!rc_ready && n < 50) begin @(negedge clk); n++; end
    check("rd_cmd_accept", {63'd0, rc_ready}, 64'd1);
    @(negedge clk);
    rc_valid = 1'b0;
    rc_data  = {$urandom, $urandom, $urandom};
  endtask

  task automatic send_wr_cmd(input logic [63:0] addr, input logic [31:0] len);
    int n;
    n = 0;
    @(negedge clk);
    wc_valid = 1'b1;
    wc_data  = {len, addr};
    while (!wc_ready && n < 50) begin @(negedge clk); n++; end
    check("wr_cmd_accept", {63'd0, wc_ready}, 64'd1);
    @(negedge clk);
    wc_valid = 1'b0;
    wc_data  = {$urandom, $urandom, $urandom};
  endtask

  // dmode 0: random data, full keep; 1: random data/keep with idle gaps; 2: 0x11*k pattern
  task automatic wr_burst(input logic [63:0] addr, input logic [31:0] len, input int nsend, input int dmode);
    int nb, base, n;
    logic [63:0] d;
    logic [7:0]  k;
    nb   = beats_of(len);
    base = idx_of(addr);
    send_wr_cmd(addr, len);
    for (int b = 1; b <= nsend; b++) begin
      if (dmode == 1 && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        wd_valid = 1'b0;
      end
      d = (dmode == 2) ? {8{8'(b * 17)}} : {$urandom, $urandom};
      k = (dmode == 1) ? 8'($urandom) : 8'hFF;
      @(negedge clk);
      wd_valid = 1'b1;
      wd_data  = d;
      wd_keep  = k;
      wd_last  = (b == nsend);
      n = 0;
      while (!wd_ready && n < 50) begin @(negedge clk); n++; end
      check("wr_data_accept", {63'd0, wd_ready}, 64'd1);
      if (b <= nb) begin
        for (int j = 0; j < 8; j++) if (k[j]) mdl[(base + b - 1) % DEPTH][j*8 +: 8] = d[j*8 +: 8];
      end
    end
    @(negedge clk);
    wd_valid = 1'b0;
    wd_last  = 1'b0;
    if (nsend != nb) exp_err++;
    check("wr_err_count", err_cnt, 64'(exp_err));
    check("wr_busy_end", {63'd0, wr_busy}, 64'd0);
  endtask

  // Scoreboard side: pops one expected beat per observed handshake.
  task automatic collect_rd(input int nb, input int mode, input bit tail);
    int got, cyc, first, lastc;
    logic [EW-1:0] e;
    got = 0; cyc = 0; first = -1; lastc = 0;
    while (got < nb && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      m_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (m_valid && m_ready) begin
        e = exp_q.pop_front();
        check("rd_data", m_data, e[63:0]);
        check("rd_keep", {56'd0, m_keep}, {56'd0, e[71:64]});
        check("rd_last", {63'd0, m_last}, {63'd0, e[72]});
        if (first < 0) first = cyc;
        lastc = cyc;
        got++;
      end
    end
    check("rd_beats", 64'(got), 64'(nb));
    if (tail) begin
      @(negedge clk);
      m_ready = 1'b0;
      check("rd_no_extra", {63'd0, m_valid}, 64'd0);
      check("rd_busy_end", {63'd0, rd_busy}, 64'd0);
      if (mode == 0 && nb > 0) check("rd_throughput", 64'(lastc - first), 64'(nb - 1));
    end
  endtask

  task automatic push_exp(input logic [63:0] addr, input logic [31:0] len);
    int nb, base;
    logic       l;
    logic [7:0] k;
    nb   = beats_of(len);
    base = idx_of(addr);
    for (int i = 0; i < nb; i++) begin
      l = (i == nb - 1);
      k = l ? keep_for(len) : 8'hFF;
      exp_q.push_back({l, k, mdl[(base + i) % DEPTH]});
    end
  endtask

  task automatic rd_burst(input logic [63:0] addr, input logic [31:0] len, input int mode);
    push_exp(addr, len);
    send_rd_cmd(addr, len);
    check("rd_first_latency", {63'd0, m_valid}, 64'd0);
    collect_rd(beats_of(len), mode, 1'b1);
  endtask

  initial begin
    logic [63:0] waddr, raddr;
    int wlen, rlen, wn, nbw;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rd_cmd_ready", {63'd0, rc_ready}, 64'd0);
    check("rst_wr_cmd_ready", {63'd0, wc_ready}, 64'd0);
    check("rst_wr_data_ready", {63'd0, wd_ready}, 64'd0);
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_m_keep", {56'd0, m_keep}, 64'd0);
    check("rst_m_last", {63'd0, m_last}, 64'd0);
    check("rst_err", {32'd0, err_cnt}, 64'd0);
    check("rst_busy", {62'd0, rd_busy, wr_busy}, 64'd0);
    check("rst_rd_state", {63'd0, rd_state_dbg}, {63'd0, RD_IDLE});
    check("rst_wr_state", {62'd0, wr_state_dbg}, {62'd0, WR_IDLE});
    rst = 1'b0;
    check("rel_ready_low", {63'd0, rc_ready}, 64'd0);
    @(negedge clk);
    check("rel_rd_ready", {63'd0, rc_ready}, 64'd1);
    check("rel_wr_ready", {63'd0, wc_ready}, 64'd1);

    // Fill the whole memory so every model word is known
    wr_burst(64'd0, 32'(DEPTH * 8), DEPTH, 0);

    // Basic 3-beat write then read back
    wr_burst(64'h100, 32'd24, 3, 2);
    rd_burst(64'h100, 32'd24, 0);
    // Partial final beat
    rd_burst(64'h0, 32'd13, 0);
    // Early last, then late last with drain
    wr_burst(64'h200, 32'd16, 1, 0);
    wr_burst(64'h300, 32'd8, 3, 0);
    rd_burst(64'h200, 32'd16, 0);
    rd_burst(64'h300, 32'd24, 0);
    // Backpressure
    rd_burst(64'h400, 32'd64, 1);
    // Wrap-around at the top word
    wr_burst(64'((DEPTH - 1) * 8), 32'd16, 2, 1);
    rd_burst(64'((DEPTH - 1) * 8), 32'd16, 1);
    // Zero-length commands
    rd_burst(64'h40, 32'd0, 0);
    check("rd_len0_ready", {63'd0, rc_ready}, 64'd1);
    wr_burst(64'h40, 32'd0, 0, 0);
    check("wr_len0_ready", {63'd0, wc_ready}, 64'd1);

    // Randomized concurrent traffic on disjoint regions, then read-back
    for (int it = 0; it < 12; it++) begin
      waddr = {$urandom, $urandom};
      raddr = {$urandom, $urandom};
      waddr[14:3] = 12'($urandom_range(0, 1999));
      raddr[14:3] = 12'($urandom_range(2100, 4000));
      wlen = $urandom_range(1, 80);
      rlen = $urandom_range(1, 80);
      nbw  = beats_of(32'(wlen));
      wn   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nbw + 2) : nbw;
      fork
        wr_burst(waddr, 32'(wlen), wn, 1);
        rd_burst(raddr, 32'(rlen), 1);
      join
      rd_burst(waddr, 32'(wlen), int'($urandom_range(0, 1)));
    end

    // Reset in the middle of an 8-beat read
    push_exp(64'h800, 32'd64);
    send_rd_cmd(64'h800, 32'd64);
    collect_rd(2, 0, 1'b0);
    @(negedge clk);
    check("rst_mid_beat3_valid", {63'd0, m_valid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid_drop", {63'd0, m_valid}, 64'd0);
    check("rst_mid_busy", {62'd0, rd_busy, wr_busy}, 64'd0);
    check("rst_mid_cmd_ready", {63'd0, rc_ready}, 64'd0);
    m_ready = 1'b0;
    exp_q.delete();
    exp_err = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready_after", {63'd0, rc_ready}, 64'd1);
    check("rst_mid_err", {32'd0, err_cnt}, 64'd0);
    rd_burst(64'h100, 32'd24, 0);
    rd_burst(64'h800, 32'd64, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
